// File: rtl/note_player_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_player_pkg
//  Description : Shared constants, state encoding and pitch table for note_player.
//  Revision    : 1.0 - initial release
// ============================================================================
package note_player_pkg;

    localparam logic [7:0] NOTE_REST = 8'h00;
    localparam logic [7:0] NOTE_END  = 8'hFF;
    localparam int         TABLE_W   = 18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_N = 3'd1,
        ST_WAIT_N  = 3'd2,
        ST_FETCH_D = 3'd3,
        ST_WAIT_D  = 3'd4,
        ST_PLAY    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Half-period in 50 MHz clocks for C3..B3; higher octaves are right shifts.
    function automatic logic [TABLE_W-1:0] half_table(input logic [3:0] semi);
        case (semi)
            4'd0:    half_table = 18'd191113;
            4'd1:    half_table = 18'd180388;
            4'd2:    half_table = 18'd170262;
            4'd3:    half_table = 18'd160705;
            4'd4:    half_table = 18'd151686;
            4'd5:    half_table = 18'd143173;
            4'd6:    half_table = 18'd135137;
            4'd7:    half_table = 18'd127552;
            4'd8:    half_table = 18'd120393;
            4'd9:    half_table = 18'd113636;
            4'd10:   half_table = 18'd107258;
            4'd11:   half_table = 18'd101239;
            default: half_table = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : note_player_if
//  Description : Read-strobe / byte bus between the stream decoder and player.
//  Revision    : 1.0 - initial release
// ============================================================================
interface note_player_if;
    logic       read;
    logic [7:0] value;

    modport master (output read, input value);
    modport slave  (input read, output value);
endinterface
`default_nettype wire

// File: rtl/note_player_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : note_player_tone_gen
//  Description : Square-wave generator; toggles audio every 'half' clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_player_tone_gen #(
    parameter int HALF_W = 18
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              clr,
    input  wire logic [HALF_W-1:0] half,
    output logic                   audio
);

    logic [HALF_W-1:0] r_cnt;
    logic              r_audio;

    // A zero half-period is a rest: hold the output low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_audio <= 1'b0;
        end else if (clr || (half == '0)) begin
            r_cnt   <= '0;
            r_audio <= 1'b0;
        end else if (r_cnt == (half - HALF_W'(1))) begin
            r_cnt   <= '0;
            r_audio <= ~r_audio;
        end else begin
            r_cnt   <= r_cnt + HALF_W'(1);
        end
    end

    assign audio = r_audio;

endmodule
`default_nettype wire

// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
//  Module      : note_player
//  Description : Fetches (note, duration) byte pairs and plays them as tones.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_player
    import note_player_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int HALF_W   = 18,
    parameter int LAT      = 1,
    parameter int GAP      = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       start,
    note_player_if.master   bus,
    output logic            audio,
    output logic [7:0]      note,
    output logic            busy,
    output logic            done
);

    localparam int c_pre_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_gap_w = $clog2(GAP + 1);
    localparam int c_lat_w = $clog2(LAT + 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_gap_w-1:0]   r_gap;
    logic [c_lat_w-1:0]   r_lat;
    logic [7:0]           r_note;
    logic [7:0]           r_dur;
    logic [c_pre_w-1:0]   r_pre;
    logic [7:0]           r_tick;

    logic                 w_fetch;
    logic                 w_wait;
    logic                 w_read;
    logic                 w_sample;
    logic                 w_start_ok;
    logic                 w_pre_wrap;
    logic                 w_play_end;
    logic [3:0]           w_semi;
    logic [2:0]           w_oct;
    logic [HALF_W-1:0]    w_half;
    logic                 w_tone;

    assign w_fetch    = (r_state == ST_FETCH_N) || (r_state == ST_FETCH_D);
    assign w_wait     = (r_state == ST_WAIT_N)  || (r_state == ST_WAIT_D);
    assign w_read     = w_fetch && (r_gap == '0);
    assign w_sample   = w_wait && (r_lat == c_lat_w'(LAT));
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_pre_wrap = (r_pre == c_pre_w'(TICK_DIV - 1));
    // Duration byte 0 wraps to a last tick of 255, i.e. 256 ticks.
    assign w_play_end = (r_state == ST_PLAY) && w_pre_wrap && (r_tick == (r_dur - 8'd1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: if (start)     w_next = ST_FETCH_N;
            ST_FETCH_N:       if (w_read)    w_next = ST_WAIT_N;
            ST_WAIT_N:        if (w_sample)  w_next = (bus.value == NOTE_END) ? ST_DONE : ST_FETCH_D;
            ST_FETCH_D:       if (w_read)    w_next = ST_WAIT_D;
            ST_WAIT_D:        if (w_sample)  w_next = ST_PLAY;
            ST_PLAY:          if (w_play_end) w_next = ST_FETCH_N;
            default:                         w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
            r_lat   <= '0;
            r_note  <= '0;
            r_dur   <= '0;
            r_pre   <= '0;
            r_tick  <= '0;
        end else begin
            r_state <= w_next;

            // Gap counter enforces the decoder refill time between read strobes.
            if (w_start_ok) begin
                r_gap <= c_gap_w'(GAP);
            end else if (w_read) begin
                r_gap <= c_gap_w'(GAP - 1);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - c_gap_w'(1);
            end

            if (w_read) begin
                r_lat <= c_lat_w'(1);
            end else if (w_wait && !w_sample) begin
                r_lat <= r_lat + c_lat_w'(1);
            end

            if (w_sample && (r_state == ST_WAIT_N)) r_note <= bus.value;
            if (w_sample && (r_state == ST_WAIT_D)) r_dur  <= bus.value;

            if (r_state != ST_PLAY) begin
                r_pre  <= '0;
                r_tick <= '0;
            end else if (w_pre_wrap) begin
                r_pre  <= '0;
                r_tick <= r_tick + 8'd1;
            end else begin
                r_pre  <= r_pre + c_pre_w'(1);
            end
        end
    end

    always_comb begin
        w_semi = r_note[3:0];
        w_oct  = r_note[6:4];
        w_half = '0;
        if ((r_note != NOTE_REST) && (w_semi < 4'd12)) begin
            w_half = HALF_W'(half_table(w_semi) >> w_oct);
        end
    end

    note_player_tone_gen #(
        .HALF_W (HALF_W)
    ) u_tone (
        .clk   (clk),
        .reset (reset),
        .clr   (r_state != ST_PLAY),
        .half  (w_half),
        .audio (w_tone)
    );

    assign bus.read = w_read;
    assign audio    = (r_state == ST_PLAY) && w_tone;
    assign note     = (r_state == ST_PLAY) ? r_note : 8'h00;
    assign busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_note_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_player
//  Description : Self-checking bench for note_player with a scripted decoder stub.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_note_player;

    localparam int TD     = 1000;
    localparam int TDZ    = 10;
    localparam int A3_HALF = 113636;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_z = 1'b0;
    logic       audio, busy, done, audio_z, busy_z, done_z;
    logic [7:0] note, note_z;

    note_player_if bus ();
    note_player_if bus_z ();

    note_player #(.TICK_DIV(TD), .HALF_W(18), .LAT(1), .GAP(4)) dut (
        .clk(clk), .reset(rst_n), .start(start), .bus(bus.master),
        .audio(audio), .note(note), .busy(busy), .done(done)
    );

    // Short-tick instance so a 256-tick event stays within a small cycle budget.
    note_player #(.TICK_DIV(TDZ), .HALF_W(18), .LAT(1), .GAP(4)) dut_z (
        .clk(clk), .reset(rst_n), .start(start_z), .bus(bus_z.master),
        .audio(audio_z), .note(note_z), .busy(busy_z), .done(done_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] note;
        int         len;
    } exp_t;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] script[$];
    logic [7:0] script_z[$];
    int         rd_log[$];
    int         rd_log_z[$];
    exp_t       exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Decoder stubs: scripted byte exactly one cycle after read, noise otherwise.
    always @(posedge clk) begin
        logic       rd;
        logic [7:0] b;
        rd = bus.read;
        b  = 8'h00;
        if (rd) begin
            rd_log.push_back(cyc);
            b = (script.size() > 0) ? script.pop_front() : 8'hFF;
        end
        #1;
        bus.value = rd ? b : 8'($urandom);
    end

    always @(posedge clk) begin
        logic       rd;
        logic [7:0] b;
        rd = bus_z.read;
        b  = 8'h00;
        if (rd) begin
            rd_log_z.push_back(cyc);
            b = (script_z.size() > 0) ? script_z.pop_front() : 8'hFF;
        end
        #1;
        bus_z.value = rd ? b : 8'($urandom);
    end

    task automatic test_reset();
        n_checks++; if (bus.read !== 1'b0) $display("FAIL rst_read: got %b want 0", bus.read); else n_pass++;
        n_checks++; if (audio !== 1'b0) $display("FAIL rst_audio: got %b want 0", audio); else n_pass++;
        n_checks++; if (note !== 8'h00) $display("FAIL rst_note: got %h want 00", note); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tone();
        int   s, t, k, prev, rise1, fall1, rise2, mingap, half;
        logic [7:0] obs;
        exp_t e;
        half = A3_HALF >> 7;
        script.push_back(8'h79); script.push_back(8'h03); script.push_back(8'hFF);
        exp_q.push_back('{note: 8'h79, len: 3 * TD});
        rd_log.delete();
        @(negedge clk); s = cyc; start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (note !== 8'h79 && t < 200) begin @(negedge clk); t++; end
        obs = note;
        k = 0; prev = 0; rise1 = -1; fall1 = -1; rise2 = -1;
        while (note === 8'h79 && k < 4 * TD) begin
            if (audio === 1'b1 && prev == 0) begin
                if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
            end
            if (audio === 1'b0 && prev == 1 && fall1 < 0) fall1 = k;
            prev = (audio === 1'b1) ? 1 : 0;
            @(negedge clk); k++;
        end
        e = exp_q.pop_front();
        n_checks++; if (obs !== e.note) $display("FAIL t1_note: got %h want %h", obs, e.note); else n_pass++;
        n_checks++; if (k != e.len) $display("FAIL t1_play_len: got %0d want %0d", k, e.len); else n_pass++;
        n_checks++; if (rise1 != half) $display("FAIL t1_rise1: got %0d want %0d", rise1, half); else n_pass++;
        n_checks++; if (fall1 != 2 * half) $display("FAIL t1_fall1: got %0d want %0d", fall1, 2 * half); else n_pass++;
        n_checks++; if (rise2 != 3 * half) $display("FAIL t1_rise2: got %0d want %0d", rise2, 3 * half); else n_pass++;
        t = 0;
        while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        n_checks++; if (done !== 1'b1) $display("FAIL t1_done: got %b want 1", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t1_busy: got %b want 0", busy); else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++; if (rd_log.size() != 3) $display("FAIL t1_reads: got %0d want 3", rd_log.size()); else n_pass++;
        mingap = 1000000;
        for (int i = 1; i < rd_log.size(); i++)
            if (rd_log[i] - rd_log[i-1] < mingap) mingap = rd_log[i] - rd_log[i-1];
        n_checks++;
        if (rd_log.size() == 0 || rd_log[0] - s < 4)
            $display("FAIL t1_first_read: got %0d want >=4", (rd_log.size() == 0) ? -1 : rd_log[0] - s);
        else n_pass++;
        n_checks++; if (mingap < 4) $display("FAIL t1_read_gap: got %0d want >=4", mingap); else n_pass++;
    endtask

    task automatic test_zero_duration();
        int   t, k, bad;
        exp_t e;
        script_z.push_back(8'h00); script_z.push_back(8'h00); script_z.push_back(8'hFF);
        exp_q.push_back('{note: 8'h00, len: 256 * TDZ});
        rd_log_z.delete();
        @(negedge clk); start_z = 1'b1;
        @(negedge clk); start_z = 1'b0;
        t = 0;
        while (rd_log_z.size() < 2 && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        k = 0; bad = 0;
        while (bus_z.read !== 1'b1 && k < 300 * TDZ) begin
            if (audio_z !== 1'b0 || note_z !== 8'h00 || busy_z !== 1'b1) bad++;
            @(negedge clk); k++;
        end
        e = exp_q.pop_front();
        n_checks++; if (k != e.len) $display("FAIL t2_rest_len: got %0d want %0d", k, e.len); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL t2_silent_busy: got %0d bad cycles want 0", bad); else n_pass++;
        t = 0;
        while (done_z !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        n_checks++; if (done_z !== 1'b1) $display("FAIL t2_done: got %b want 1", done_z); else n_pass++;
    endtask

    task automatic test_end_only();
        int t;
        script.push_back(8'hFF);
        rd_log.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++; if (done !== 1'b0) $display("FAIL t3_done_clear: got %b want 0", done); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL t3_busy: got %b want 1", busy); else n_pass++;
        t = 0;
        while (done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        n_checks++; if (done !== 1'b1) $display("FAIL t3_done: got %b want 1", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t3_idle_busy: got %b want 0", busy); else n_pass++;
        repeat (30) @(negedge clk);
        n_checks++; if (rd_log.size() != 1) $display("FAIL t3_reads: got %0d want 1", rd_log.size()); else n_pass++;
    endtask

    task automatic test_high_semitone();
        int   t, k, bad;
        exp_t e;
        logic [7:0] obs;
        script.push_back(8'h0C); script.push_back(8'h02); script.push_back(8'hFF);
        exp_q.push_back('{note: 8'h0C, len: 2 * TD});
        rd_log.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL t4_done_clear: got %b want 0", done); else n_pass++;
        t = 0;
        while (rd_log.size() < 2 && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        obs = note;
        k = 0; bad = 0;
        while (bus.read !== 1'b1 && k < 3 * TD) begin
            if (audio !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk); k++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if (obs !== e.note) $display("FAIL t4_note: got %h want %h", obs, e.note); else n_pass++;
        n_checks++; if (k != e.len) $display("FAIL t4_rest_len: got %0d want %0d", k, e.len); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL t4_silent: got %0d bad cycles want 0", bad); else n_pass++;
        t = 0;
        while (done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        n_checks++; if (done !== 1'b1) $display("FAIL t4_done: got %b want 1", done); else n_pass++;
    endtask

    task automatic test_async_reset();
        int t;
        // Abort mid-PLAY while the tone is high.
        script.push_back(8'h79); script.push_back(8'h05);
        rd_log.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (note !== 8'h79 && t < 200) begin @(negedge clk); t++; end
        repeat (900) @(negedge clk);
        n_checks++; if (audio !== 1'b1) $display("FAIL t5_pre_audio: got %b want 1", audio); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (audio !== 1'b0) $display("FAIL t5p_audio: got %b want 0", audio); else n_pass++;
        n_checks++; if (note !== 8'h00) $display("FAIL t5p_note: got %h want 00", note); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t5p_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.read !== 1'b0) $display("FAIL t5p_read: got %b want 0", bus.read); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        script.delete();
        repeat (50) @(negedge clk);
        n_checks++; if (rd_log.size() != 2) $display("FAIL t5p_no_reads: got %0d want 2", rd_log.size()); else n_pass++;
        // Abort mid-WAIT: the fetched note must never play.
        script.push_back(8'h79); script.push_back(8'h05);
        rd_log.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (bus.read !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL t5w_pre_busy: got %b want 1", busy); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL t5w_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL t5w_done: got %b want 0", done); else n_pass++;
        n_checks++; if (bus.read !== 1'b0) $display("FAIL t5w_read: got %b want 0", bus.read); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        script.delete();
        t = 0;
        repeat (50) begin
            @(negedge clk);
            if (note !== 8'h00 || audio !== 1'b0 || busy !== 1'b0) t++;
        end
        n_checks++; if (rd_log.size() != 1) $display("FAIL t5w_reads: got %0d want 1", rd_log.size()); else n_pass++;
        n_checks++; if (t != 0) $display("FAIL t5w_idle: got %0d active cycles want 0", t); else n_pass++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_tone();
        test_zero_duration();
        test_end_only();
        test_high_semitone();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
